key_io_device: RTL and testbench
================================

Name: key_io_device

Overview:
- Memory-mapped KEY peripheral on the CPU's data-memory stage bus, beside the SW/LEDR/HEX decode.
- Synchronizes and debounces the four active-low KEY inputs.
- Exposes the debounced state in a data register (KDATA) and a ready/overrun/interrupt-enable status register (KCTRL).
- The memory stage reads it in the same cycle, with read side-effects committed at the clock edge.

Parameters:
DBITS, 32, bus data/address width
NKEYS, 4, number of key inputs
DEBOUNCE_CYCLES, 500000, consecutive stable cycles required to accept a new key level (10 ms at 50 MHz); must be >= 2
ADDR_KDATA, 32'hF0000010, KDATA register address
ADDR_KCTRL, 32'hF0000110, KCTRL register address

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
addr  in  DBITS  byte address from the memory stage
rd_en  in  1  load in progress this cycle
wr_en  in  1  store in progress this cycle
wdata  in  DBITS  store data
key_n  in  NKEYS  raw KEY pins, active-low, asynchronous
sel  out  1  addr equals ADDR_KDATA or ADDR_KCTRL (combinational)
rdata  out  DBITS  read data (combinational from addr and register state)
irq  out  1  ready AND ie, registered-state derived

Behaviour:
- Interface: one clock, clk; reset is asynchronous and active-high, named reset.
- Reset values:
  - synchronizer flops = 1 (released)
  - debounced state = 0
  - debounce counters = 0
  - ready = 0, overrun = 0, ie = 0
  - Resulting outputs: irq = 0, sel = f(addr), rdata = 0 for any selected address.
- Input path: each key_n bit passes through a 2-flop synchronizer and is inverted, giving pressed = 1.
- Debounce, per key:
  - If the synchronized level equals the debounced level, the counter clears to 0.
  - Otherwise the counter increments.
  - When a mismatch is seen with counter == DEBOUNCE_CYCLES-1, the debounced level takes the synchronized level and the counter clears.
  - Any return to agreement before then aborts the change.
  - Counter width = $clog2(DEBOUNCE_CYCLES). It never wraps.
  - Total latency from pin edge to KDATA change = 2 + DEBOUNCE_CYCLES cycles.
- KDATA read value: bits[NKEYS-1:0] = debounced state; upper bits = 0.
- KCTRL read value: bit0 ready, bit1 overrun, bit8 ie; all other bits 0.
- rdata = 0 when sel = 0.
- Per-cycle ready/overrun update, evaluated in this order:
  - change = any debounced bit updates this cycle.
  - kread = rd_en && addr == ADDR_KDATA.
  - change && ready && !kread: overrun <= 1.
  - change: ready <= 1. This wins over kread in the same cycle; overrun is not set in that case.
  - kread && !change: ready <= 0.
- KCTRL write (wr_en && addr == ADDR_KCTRL):
  - ie <= wdata[8].
  - wdata[1] == 0 clears overrun; writing 1 leaves it unchanged.
  - ready is not writable.
  - If an overrun-setting event and an overrun clear occur in the same cycle, set wins.
- Writes to KDATA are ignored.
- rd_en and wr_en both high: the store is processed and the read side-effect is still applied.
- Reset asserted mid-debounce or mid-access: all state returns to reset values immediately. A key held through reset is re-accepted DEBOUNCE_CYCLES+2 cycles after reset deasserts.

Decomposition:
- Package key_io_pkg holds:
  - the address constants
  - KCTRL bit indices: READY_BIT = 0, OVERRUN_BIT = 1, IE_BIT = 8
  - reset value of the synchronizer flops
- Sub-module key_debouncer, instantiated NKEYS times. It contains one synchronizer, one counter and one debounced bit, and outputs level and changed.
- Register and decode logic stays in key_io_device.

Test Plan:
All scenarios use DEBOUNCE_CYCLES = 4 in simulation.
1. Reset: assert reset asynchronously mid-cycle with KEY0 held -> all regs 0, irq = 0. Deassert -> KDATA = 0x1 exactly 6 cycles later, ready = 1.
2. Bounce: toggle key_n[2] every 2 cycles for 20 cycles, then settle low -> KDATA stays 0x0 while toggling and becomes 0x4 6 cycles after settling. Exactly one ready assertion.
3. Read clears ready: after a press, read ADDR_KDATA -> rdata = 0x1, ready = 0 next cycle. A KCTRL read then returns 0x0.
4. Overrun: press KEY1 and release without reading -> KCTRL = 0x3. Write 0x100 to KCTRL -> KCTRL = 0x101, irq = 1. Read KDATA -> irq = 0.
5. Collision: debounced change on the same cycle as a KDATA read -> ready stays 1, overrun stays 0. Non-matching address 0xF0000014 -> sel = 0, rdata = 0, no state change.

Source files
------------

// File: rtl/key_io_pkg.sv
// Shared constants for the KEY peripheral: bus addresses, KCTRL bit layout and
// synchronizer reset level.
package key_io_pkg;

  localparam logic [31:0] KEY_KDATA_ADDR = 32'hF000_0010;
  localparam logic [31:0] KEY_KCTRL_ADDR = 32'hF000_0110;

  localparam int READY_BIT   = 0;
  localparam int OVERRUN_BIT = 1;
  localparam int IE_BIT      = 8;

  // Raw pins are active-low, so "released" is the safe power-up level.
  localparam logic SYNC_RST_VAL = 1'b1;

  function automatic logic [31:0] kctrl_word(input logic ready,
                                             input logic overrun,
                                             input logic ie);
    logic [31:0] w;
    w              = '0;
    w[READY_BIT]   = ready;
    w[OVERRUN_BIT] = overrun;
    w[IE_BIT]      = ie;
    return w;
  endfunction

endpackage

// File: rtl/key_io_device_debouncer.sv
// One KEY channel: 2-flop synchronizer, inversion to pressed=1, and a
// stable-run counter that accepts a new level after DEBOUNCE_CYCLES agreeing samples.
module key_debouncer
  import key_io_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic reset,
  input  logic key_n,
  output logic level,
  output logic changed
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync_p0;
  logic             sync_p1;
  logic             pressed;
  logic [CNT_W-1:0] cnt;

  // Stage p0/p1: metastability guard on the asynchronous pin
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_p0 <= SYNC_RST_VAL;
      sync_p1 <= SYNC_RST_VAL;
    end else begin
      sync_p0 <= key_n;
      sync_p1 <= sync_p0;
    end
  end

  assign pressed = ~sync_p1;
  assign changed = (pressed != level) && (cnt == CNT_LAST);

  // Counter only runs while the synchronized level disagrees, so it never wraps.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      level <= 1'b0;
      cnt   <= '0;
    end else if (pressed == level) begin
      cnt <= '0;
    end else if (cnt == CNT_LAST) begin
      level <= pressed;
      cnt   <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/key_io_device.sv
// Memory-mapped KEY peripheral: debounced key state in KDATA, ready/overrun/ie
// status in KCTRL, and a level interrupt while ready and ie are both set.
module key_io_device
  import key_io_pkg::*;
#(
  parameter int               DBITS           = 32,
  parameter int               NKEYS           = 4,
  parameter int               DEBOUNCE_CYCLES = 500000,
  parameter logic [DBITS-1:0] ADDR_KDATA      = DBITS'(KEY_KDATA_ADDR),
  parameter logic [DBITS-1:0] ADDR_KCTRL      = DBITS'(KEY_KCTRL_ADDR)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [DBITS-1:0] addr,
  input  logic             rd_en,
  input  logic             wr_en,
  input  logic [DBITS-1:0] wdata,
  input  logic [NKEYS-1:0] key_n,
  output logic             sel,
  output logic [DBITS-1:0] rdata,
  output logic             irq
);

  logic [NKEYS-1:0] deb_level;
  logic [NKEYS-1:0] deb_changed;
  logic             ready;
  logic             overrun;
  logic             ie;
  logic             change;
  logic             hit_kdata;
  logic             hit_kctrl;
  logic             kread;
  logic             kctrl_wr;
  logic             ovr_set;
  logic             ovr_clr;
  logic             unused_wdata;

  for (genvar i = 0; i < NKEYS; i++) begin : g_key
    key_debouncer #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_deb (
      .clk    (clk),
      .reset  (reset),
      .key_n  (key_n[i]),
      .level  (deb_level[i]),
      .changed(deb_changed[i])
    );
  end

  assign hit_kdata = (addr == ADDR_KDATA);
  assign hit_kctrl = (addr == ADDR_KCTRL);
  assign sel       = hit_kdata | hit_kctrl;

  assign change   = |deb_changed;
  assign kread    = rd_en && hit_kdata;
  assign kctrl_wr = wr_en && hit_kctrl;
  // A fresh key event overwrites an unread one; a read in the same cycle consumes it.
  assign ovr_set  = change && ready && !kread;
  assign ovr_clr  = kctrl_wr && !wdata[OVERRUN_BIT];

  assign unused_wdata = ^{wdata[DBITS-1:IE_BIT+1], wdata[IE_BIT-1:OVERRUN_BIT+1],
                          wdata[READY_BIT]};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ready   <= 1'b0;
      overrun <= 1'b0;
      ie      <= 1'b0;
    end else begin
      if (kctrl_wr) ie <= wdata[IE_BIT];

      if (ovr_set)      overrun <= 1'b1;
      else if (ovr_clr) overrun <= 1'b0;

      if (change)     ready <= 1'b1;
      else if (kread) ready <= 1'b0;
    end
  end

  always_comb begin
    rdata = '0;
    if (hit_kdata)      rdata = DBITS'(deb_level);
    else if (hit_kctrl) rdata = DBITS'(kctrl_word(ready, overrun, ie));
  end

  assign irq = ready & ie;

endmodule

// File: tb/tb_key_io_device.sv
// Randomized scoreboard bench for key_io_device with a window-based key model.
module tb_key_io_device;
  import key_io_pkg::*;

  localparam int DBITS = 32;
  localparam int NKEYS = 4;
  localparam int DC    = 4;
  localparam logic [31:0] ADDR_OTHER = 32'hF000_0014;

  logic             clk = 1'b0;
  logic             reset;
  logic [DBITS-1:0] addr;
  logic             rd_en;
  logic             wr_en;
  logic [DBITS-1:0] wdata;
  logic [NKEYS-1:0] key_n;
  logic             sel;
  logic [DBITS-1:0] rdata;
  logic             irq;

  always #5 clk = ~clk;

  key_io_device #(
    .DBITS(DBITS), .NKEYS(NKEYS), .DEBOUNCE_CYCLES(DC)
  ) dut (
    .clk(clk), .reset(reset), .addr(addr), .rd_en(rd_en), .wr_en(wr_en),
    .wdata(wdata), .key_n(key_n), .sel(sel), .rdata(rdata), .irq(irq)
  );

  typedef struct packed {
    logic        sel;
    logic [31:0] rdata;
    logic        irq;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  // Reference model: pins seen two edges late; a key flips once the last DC
  // samples all disagree with its accepted level.
  logic [NKEYS-1:0] m_deb;
  logic             m_rdy, m_ov, m_ie;
  logic [NKEYS-1:0] pin_hist[$];
  logic [NKEYS-1:0] win[$];

  function automatic void model_reset();
    m_deb = '0; m_rdy = 1'b0; m_ov = 1'b0; m_ie = 1'b0;
    pin_hist = {};
    pin_hist.push_back('1);
    pin_hist.push_back('1);
    win = {};
  endfunction

  function automatic void model_step();
    logic [NKEYS-1:0] smp;
    logic [NKEYS-1:0] flip;
    logic             chg, kr, wc;
    bit               all_diff;
    pin_hist.push_back(key_n);
    smp = pin_hist.pop_front();
    win.push_back(~smp);
    if (win.size() > DC) void'(win.pop_front());
    flip = '0;
    if (win.size() == DC) begin
      for (int i = 0; i < NKEYS; i++) begin
        all_diff = 1;
        for (int j = 0; j < win.size(); j++)
          if (win[j][i] == m_deb[i]) all_diff = 0;
        if (all_diff) flip[i] = 1'b1;
      end
    end
    m_deb = m_deb ^ flip;
    chg = |flip;
    kr  = rd_en && (addr == KEY_KDATA_ADDR);
    wc  = wr_en && (addr == KEY_KCTRL_ADDR);
    if (wc) begin
      m_ie = wdata[8];
      if (!wdata[1]) m_ov = 1'b0;
    end
    if (chg && m_rdy && !kr) m_ov = 1'b1;
    if (chg) m_rdy = 1'b1;
    else if (kr) m_rdy = 1'b0;
  endfunction

  function automatic exp_t model_out();
    exp_t e;
    e.sel   = (addr == KEY_KDATA_ADDR) || (addr == KEY_KCTRL_ADDR);
    e.rdata = '0;
    if (addr == KEY_KDATA_ADDR) e.rdata = 32'(m_deb);
    else if (addr == KEY_KCTRL_ADDR) e.rdata = {23'b0, m_ie, 6'b0, m_ov, m_rdy};
    e.irq   = m_rdy & m_ie;
    return e;
  endfunction

  // One bus cycle: advance the model at the edge, then drive new inputs and
  // queue what the DUT must show for them.
  task automatic cycle(input logic r, input logic [31:0] a, input logic rd,
                       input logic wr, input logic [31:0] wd, input logic [NKEYS-1:0] kn);
    @(posedge clk);
    if (reset) model_reset();
    else model_step();
    #1;
    reset = r; addr = a; rd_en = rd; wr_en = wr; wdata = wd; key_n = kn;
    if (r) model_reset();
    exp_q.push_back(model_out());
  endtask

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h at %0t", nm, got, want, $time);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("sel", 32'(sel), 32'(e.sel));
        chk("rdata", rdata, e.rdata);
        chk("irq", 32'(irq), 32'(e.irq));
      end
    end
  end

  function automatic logic [31:0] pick_addr();
    case ($urandom_range(0, 5))
      0, 1:    return KEY_KDATA_ADDR;
      2, 3:    return KEY_KCTRL_ADDR;
      4:       return ADDR_OTHER;
      default: return $urandom;
    endcase
  endfunction

  initial begin : driver
    logic [NKEYS-1:0] kn;
    logic             r;
    reset = 1'b1; addr = KEY_KCTRL_ADDR; rd_en = 0; wr_en = 0; wdata = '0; key_n = '1;
    model_reset();
    kn = '1;

    repeat (3) cycle(1, KEY_KCTRL_ADDR, 0, 0, 0, kn);
    repeat (2) cycle(0, KEY_KDATA_ADDR, 0, 0, 0, kn);

    // Reset arriving mid-debounce with KEY0 held, then re-acceptance
    kn = 4'b1110;
    repeat (3) cycle(0, KEY_KDATA_ADDR, 0, 0, 0, kn);
    repeat (2) cycle(1, KEY_KDATA_ADDR, 0, 0, 0, kn);
    repeat (8) cycle(0, KEY_KDATA_ADDR, 0, 0, 0, kn);
    cycle(0, KEY_KCTRL_ADDR, 0, 0, 0, kn);
    kn = '1;
    repeat (8) cycle(0, KEY_KCTRL_ADDR, 0, 0, 0, kn);

    // Bounce on KEY2 then settle pressed
    for (int i = 0; i < 20; i++) begin
      if (i % 2 == 0) kn[2] = ~kn[2];
      cycle(0, KEY_KCTRL_ADDR, 0, 0, 0, kn);
    end
    kn[2] = 1'b0;
    repeat (8) cycle(0, KEY_KCTRL_ADDR, 0, 0, 0, kn);

    // Read clears ready
    cycle(0, KEY_KDATA_ADDR, 1, 0, 0, kn);
    cycle(0, KEY_KCTRL_ADDR, 1, 0, 0, kn);
    kn = '1;
    repeat (8) cycle(0, KEY_KCTRL_ADDR, 0, 0, 0, kn);
    cycle(0, KEY_KDATA_ADDR, 1, 0, 0, kn);

    // Overrun, interrupt enable, and clearing via read
    kn[1] = 1'b0;
    repeat (8) cycle(0, KEY_KCTRL_ADDR, 0, 0, 0, kn);
    kn[1] = 1'b1;
    repeat (8) cycle(0, KEY_KCTRL_ADDR, 0, 0, 0, kn);
    cycle(0, KEY_KCTRL_ADDR, 0, 1, 32'h100, kn);
    cycle(0, KEY_KCTRL_ADDR, 0, 0, 0, kn);
    cycle(0, KEY_KDATA_ADDR, 1, 0, 0, kn);
    cycle(0, KEY_KCTRL_ADDR, 0, 0, 0, kn);
    cycle(0, KEY_KCTRL_ADDR, 0, 1, 32'h102, kn);
    cycle(0, KEY_KCTRL_ADDR, 0, 0, 0, kn);

    // Debounced change colliding with back-to-back KDATA reads
    kn[3] = 1'b0;
    repeat (10) cycle(0, KEY_KDATA_ADDR, 1, 0, 0, kn);
    cycle(0, KEY_KCTRL_ADDR, 0, 0, 0, kn);
    cycle(0, ADDR_OTHER, 1, 1, 32'hFFFF_FFFF, kn);
    cycle(0, KEY_KCTRL_ADDR, 0, 0, 0, kn);

    // Randomized traffic with sporadic asynchronous resets
    r = 1'b0;
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 9) == 0) kn[$urandom_range(0, NKEYS - 1)] ^= 1'b1;
      if (r) r = ($urandom_range(0, 1) == 0);
      else r = ($urandom_range(0, 399) == 0);
      cycle(r, pick_addr(), ($urandom_range(0, 3) == 0), ($urandom_range(0, 5) == 0),
            $urandom, kn);
    end

    repeat (2) @(posedge clk);
    if (exp_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL queue_drain left=%0d want=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
